// File: rtl/multi_issue_queue.sv
// N-way circular issue queue: up to WAYS pushes and WAYS pops per cycle,
// oldest WAYS entries presented combinationally, with flush and clamped over-pop.

module miq_rd_lane #(
  parameter int DATA_W = 64,
  parameter int CW     = 5,
  parameter int LANE   = 0
) (
  input  logic [CW-1:0]     count_i,
  input  logic [DATA_W-1:0] entry_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);
  // Lanes beyond the occupancy read stale storage, so they are masked to zero.
  assign valid_o = (CW'(LANE) < count_i);
  assign data_o  = valid_o ? entry_i : '0;
endmodule

module multi_issue_queue #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int WAYS   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [WAYS*DATA_W-1:0]     in_data,
  input  logic [$clog2(WAYS+1)-1:0]  in_data_number,
  output logic                       push_accept,
  output logic [WAYS*DATA_W-1:0]     out_data,
  output logic [WAYS-1:0]            out_valid,
  input  logic [$clog2(WAYS+1)-1:0]  out_data_number,
  output logic [$clog2(DEPTH+1)-1:0] size,
  output logic [$clog2(DEPTH+1)-1:0] size_left
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int NW = $clog2(WAYS+1);

  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d, left_q, left_d;
  logic [CW-1:0]     push_n, pop_n;
  logic [CW:0]       count_ext;
  logic              wr_en;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign push_n      = CW'(in_data_number);
  // Admission uses the registered free count; a same-cycle pop frees nothing.
  assign push_accept = (push_n <= left_q);
  assign pop_n       = (CW'(out_data_number) < count_q) ? CW'(out_data_number) : count_q;
  assign wr_en       = push_accept && !flush && !rst;

  always_comb begin
    head_d    = head_q + PW'(pop_n);
    tail_d    = tail_q + (wr_en ? PW'(push_n) : '0);
    count_ext = {1'b0, count_q} + (wr_en ? {1'b0, push_n} : '0) - {1'b0, pop_n};
    count_d   = (count_ext > (CW+1)'(DEPTH)) ? CW'(DEPTH) : count_ext[CW-1:0];
    left_d    = CW'(DEPTH) - count_d;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      left_d  = CW'(DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      left_q  <= CW'(DEPTH);
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      left_q  <= left_d;
    end
  end

  // Storage is deliberately not reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < WAYS; i++) begin
        if (NW'(i) < in_data_number)
          mem_q[tail_q + PW'(i)] <= in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_lane
    miq_rd_lane #(.DATA_W(DATA_W), .CW(CW), .LANE(g)) u_lane (
      .count_i (count_q),
      .entry_i (mem_q[head_q + PW'(g)]),
      .data_o  (out_data[g*DATA_W +: DATA_W]),
      .valid_o (out_valid[g])
    );
  end

  assign size      = count_q;
  assign size_left = left_q;
endmodule

// File: tb/tb_multi_issue_queue.sv
// Bench for multi_issue_queue (DEPTH=16, WAYS=2): queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.

module tb_multi_issue_queue;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [127:0] in_data = '0;
  logic [1:0]   in_n = '0;
  logic [1:0]   pop_n = '0;
  logic         pa;
  logic [127:0] out_data;
  logic [1:0]   out_valid;
  logic [4:0]   size, size_left;

  int errors = 0;
  int checks = 0;
  logic pa_last;

  multi_issue_queue #(.DATA_W(64), .DEPTH(16), .WAYS(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_data         (in_data),
    .in_data_number  (in_n),
    .push_accept     (pa),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_data_number (pop_n),
    .size            (size),
    .size_left       (size_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of values, updated with the rules of the queue.
  longint unsigned mq[$];
  bit model_on = 0;
  int m_p;
  bit m_acc;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      model_on = 1;
    end else if (model_on) begin
      m_acc = (int'(in_n) <= 16 - mq.size());
      if (flush) mq.delete();
      else begin
        m_p = (int'(pop_n) < mq.size()) ? int'(pop_n) : mq.size();
        for (int i = 0; i < m_p; i++) void'(mq.pop_front());
        if (m_acc)
          for (int i = 0; i < int'(in_n); i++) mq.push_back(in_data[i*64 +: 64]);
      end
    end
  end

  always @(negedge clk) begin
    if (model_on && !rst) begin
      chk("size", 64'(size), 64'(mq.size()));
      chk("size_left", 64'(size_left), 64'(16 - mq.size()));
      chk("push_accept", 64'(pa), 64'(int'(in_n) <= 16 - mq.size()));
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(i < mq.size()));
        chk($sformatf("out_data[%0d]", i), out_data[i*64 +: 64],
            (i < mq.size()) ? mq[i] : 64'd0);
      end
    end
  end

  task automatic step(input bit r, input bit f, input int n,
                      input longint unsigned d0, input longint unsigned d1, input int p);
    rst     = r;
    flush   = f;
    in_n    = 2'(n);
    in_data = {d1, d0};
    pop_n   = 2'(p);
    #1 pa_last = pa;
    @(posedge clk);
    #1;
  endtask

  task automatic lanes(input string name, input longint unsigned e0, input longint unsigned e1);
    chk({name, "_l0"}, out_data[63:0], e0);
    chk({name, "_l1"}, out_data[127:64], e1);
  endtask

  initial begin
    // 1. reset and idle
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t1_size", 64'(size), 0);
    chk("t1_left", 64'(size_left), 16);
    chk("t1_valid", 64'(out_valid), 0);
    chk("t1_data", out_data[63:0] | out_data[127:64], 0);
    in_n = 2'd2;
    #1 chk("t1_pa_n2", 64'(pa), 1);
    in_n = 2'd0;

    // 2. fill to full, over-push rejected, then pop 2
    for (int k = 0; k < 8; k++) step(0, 0, 2, 2*k+1, 2*k+2, 0);
    chk("t2_full_size", 64'(size), 16);
    chk("t2_full_left", 64'(size_left), 0);
    step(0, 0, 1, 17, 0, 0);
    chk("t2_pa_full", 64'(pa_last), 0);
    chk("t2_size_hold", 64'(size), 16);
    lanes("t2_head", 1, 2);
    step(0, 0, 0, 0, 0, 2);
    chk("t2_pop_size", 64'(size), 14);
    lanes("t2_after_pop", 3, 4);

    // 3. wrap-around streaming
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) step(0, 0, 2, 2*k+1, 2*k+2, 0);
    step(0, 0, 1, 15, 0, 0);
    chk("t3_size15", 64'(size), 15);
    for (int k = 0; k < 7; k++) step(0, 0, 0, 0, 0, 2);
    chk("t3_size1", 64'(size), 1);
    lanes("t3_one", 15, 0);
    for (int j = 0; j < 20; j++) begin
      step(0, 0, 2, 16+2*j, 17+2*j, 2);
      if (j == 0) lanes("t3_straddle", 16, 17);
    end
    chk("t3_size_end", 64'(size), 2);
    lanes("t3_end", 54, 55);

    // 4. over-pop clamp with simultaneous push
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 100, 0, 0);
    step(0, 0, 2, 101, 102, 2);
    chk("t4_size", 64'(size), 2);
    chk("t4_valid", 64'(out_valid), 3);
    lanes("t4", 101, 102);

    // 5. flush wins over push and pop
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 2, 2*k+1, 2*k+2, 0);
    step(0, 0, 1, 9, 0, 0);
    chk("t5_size9", 64'(size), 9);
    step(0, 1, 2, 300, 301, 1);
    chk("t5_flush_size", 64'(size), 0);
    chk("t5_flush_left", 64'(size_left), 16);
    chk("t5_flush_valid", 64'(out_valid), 0);
    step(0, 0, 2, 200, 201, 0);
    chk("t5_after_size", 64'(size), 2);
    lanes("t5_after", 200, 201);

    // 6. random traffic, push-heavy then pop-heavy phases
    for (int c = 0; c < 3000; c++) begin
      int n, p;
      if (c < 1500) begin
        n = $urandom_range(0, 3); if (n == 3) n = 2;
        p = $urandom_range(0, 2);
        if ($urandom_range(0, 2) == 0) p = 0;
      end else begin
        n = $urandom_range(0, 2);
        p = $urandom_range(0, 3); if (p == 3) p = 2;
        if ($urandom_range(0, 2) == 0) n = 0;
      end
      step($urandom_range(0, 299) == 0, $urandom_range(0, 149) == 0, n,
           {$urandom, $urandom}, {$urandom, $urandom}, p);
    end
    step(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
